// File: rtl/cpu_pkg.sv
// Shared CPU types and widths used by the register file and the write-back stage.
package cpu_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

  // True when the address names the hardwired zero register.
  function automatic logic is_zero_reg(input int zero_reg_en, input reg_addr_t addr);
    return (zero_reg_en != 0) && (addr == '0);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: zero/bypass/array priority select plus data and valid flops.
module regfile_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::REG_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] array_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] rd_data_reg;
  logic [DATA_W-1:0] rd_data_next;
  logic              rd_valid_reg;
  logic              addr_is_zero;
  logic              bypass_hit;

  assign addr_is_zero = (ZERO_REG != 0) && (rd_addr == '0);
  assign bypass_hit   = wr_en && (wr_addr == rd_addr);

  // Zero register wins over bypass, so a dropped R0 write never leaks through.
  always_comb begin
    rd_data_next = array_data;
    if (addr_is_zero) begin
      rd_data_next = '0;
    end else if (bypass_hit) begin
      rd_data_next = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) begin
        rd_data_reg <= rd_data_next;
      end
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: rtl/register_file.sv
// Architectural register file: single write-back port, two registered read ports
// with same-cycle write-to-read bypass.
module register_file
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::REG_ADDR_W,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_drop;

  assign wr_drop = (ZERO_REG != 0) && (wr_addr == '0);

  // Storage is cleared on reset, so it stays in fabric flops rather than block RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && !wr_drop) begin
      regs[wr_addr] <= wr_data;
    end
  end

  logic              port_rd_en    [2];
  logic [ADDR_W-1:0] port_rd_addr  [2];
  logic [DATA_W-1:0] port_rd_data  [2];
  logic              port_rd_valid [2];

  assign port_rd_en[0]   = rd_en_a;
  assign port_rd_addr[0] = rd_addr_a;
  assign port_rd_en[1]   = rd_en_b;
  assign port_rd_addr[1] = rd_addr_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      regfile_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
      ) u_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (port_rd_en[gi]),
        .rd_addr    (port_rd_addr[gi]),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .array_data (regs[port_rd_addr[gi]]),
        .rd_data    (port_rd_data[gi]),
        .rd_valid   (port_rd_valid[gi])
      );
    end
  endgenerate

  assign rd_data_a  = port_rd_data[0];
  assign rd_valid_a = port_rd_valid[0];
  assign rd_data_b  = port_rd_data[1];
  assign rd_valid_b = port_rd_valid[1];

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file: the receiving end of the write-back interface, plus the read ports used by decode.
- Accepts one write per cycle from write-back (write data, 4-bit register address, write enable).
- Serves two independent registered read ports to the decode/operand-fetch stage.
- Same-cycle write-to-read bypass, so a value retired this cycle is visible to a read issued this cycle.

Parameters:
- DATA_W, 16, register and data width.
- ADDR_W, 4, register address width.
- NUM_REGS, 16, number of registers; must equal 2**ADDR_W.
- ZERO_REG, 1, if 1 then R0 is hardwired to zero (writes dropped, reads return 0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active low.
- wr_en  input  1  write enable from write-back.
- wr_addr  input  ADDR_W  destination register from write-back.
- wr_data  input  DATA_W  write-back data.
- rd_en_a  input  1  read request, port A.
- rd_addr_a  input  ADDR_W  source register, port A.
- rd_data_a  output  DATA_W  registered read data, port A.
- rd_valid_a  output  1  rd_data_a updated this cycle.
- rd_en_b  input  1  read request, port B.
- rd_addr_b  input  ADDR_W  source register, port B.
- rd_data_b  output  DATA_W  registered read data, port B.
- rd_valid_b  output  1  rd_data_b updated this cycle.

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n), sampled only at the rising edge of clk.
- Reset, on a posedge with rst_n=0:
  - all NUM_REGS registers <= 0
  - rd_data_a and rd_data_b <= 0
  - rd_valid_a and rd_valid_b <= 0
  - any wr_en or rd_en in that cycle is ignored
- Write, on a posedge with rst_n=1 and wr_en=1:
  - regs[wr_addr] <= wr_data
  - if ZERO_REG=1 and wr_addr=0, the write is dropped and R0 stays 0
  - wr_en=0 leaves all registers unchanged
- Read, per port X in {a,b}, on a posedge with rst_n=1:
  - rd_valid_X <= rd_en_X
  - if rd_en_X=1, rd_data_X <= read value, selected in priority order:
    1. ZERO_REG=1 and rd_addr_X=0 -> 0
    2. wr_en=1 and wr_addr==rd_addr_X (and not the dropped R0 case) -> wr_data (bypass)
    3. otherwise -> regs[rd_addr_X] (pre-edge value)
  - if rd_en_X=0, rd_data_X holds its previous value and rd_valid_X=0
- Latency: read address to data is exactly 1 cycle. Write is visible in storage from the next cycle, and to a same-cycle read through the bypass.
- Simultaneous events:
  - both ports may read the same address, or the written address, in the same cycle; each port resolves independently with identical results.
  - there is only one write port, so no write-write conflict is possible.
- Back-to-back: a write in cycle N followed by a read without bypass in cycle N+1 returns the new value.
- Reset mid-operation: a read issued in a reset cycle produces no valid; storage is cleared even if a write was pending.
- No X propagation: all outputs are defined from the first reset onward.

Decomposition:
- Shared package cpu_pkg holds: DATA_W=16, REG_ADDR_W=4, NUM_REGS=16, typedef reg_addr_t (logic [3:0]), typedef word_t (logic [15:0]). The write-back stage uses the same package.
- One sub-module, regfile_read_port:
  - contains the priority mux (zero/bypass/array) and the output and valid flops
  - instantiated twice (ports A, B)
- Storage array and write logic live in register_file.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with wr_en=1, wr_addr=3, wr_data=16'hFFFF. Release, then read A=3 -> rd_data_a=16'h0000 one cycle later, rd_valid_a=1; all outputs 0 during reset.
- Write then read: write R5=16'h1234 in cycle N; read A=5 in cycle N+1 -> rd_data_a=16'h1234 at N+2. rd_en_a=0 at N+2 -> rd_data_a holds 16'h1234, rd_valid_a=0.
- Bypass: R7 holds 16'h00AA; in the same cycle write R7=16'hBEEF and read A=7, B=7 -> next cycle rd_data_a=rd_data_b=16'hBEEF; the following read of R7 also returns 16'hBEEF.
- Zero register: write R0=16'h5555, and in the same cycle read A=0 -> rd_data_a=0; a later read of R0 -> 0. With ZERO_REG=0, the same sequence -> 16'h5555 on both reads.
- Dual port independent: R1=16'h0001, R15=16'hF00F; read A=1, B=15 while writing R2=16'h2222 -> rd_data_a=16'h0001, rd_data_b=16'hF00F.
- Reset mid-stream: R4=16'h4444; assert rst_n=0 for 1 cycle while reading A=4 -> rd_valid_a=0 after that edge; a subsequent read of R4 -> 16'h0000.
